// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, WB bypass, flush and stall counter
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             flush,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [2:0]       id_funct3,
    input  logic             id_funct7b5,
    input  logic             id_RegWrite,
    input  logic             id_MemtoReg,
    input  logic             id_MemRead,
    input  logic             id_MemWrite,
    input  logic             id_ALUSrc,
    input  logic             id_Branch,
    input  logic [1:0]       id_ALUOp,
    input  logic             wb_RegWrite,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic             IDEX_valid,
    output logic [XLEN-1:0]  IDEX_pc,
    output logic [XLEN-1:0]  IDEX_rs1_data,
    output logic [XLEN-1:0]  IDEX_rs2_data,
    output logic [XLEN-1:0]  IDEX_imm,
    output logic [4:0]       IDEX_rs1,
    output logic [4:0]       IDEX_rs2,
    output logic [4:0]       IDEX_rd,
    output logic [2:0]       IDEX_funct3,
    output logic             IDEX_funct7b5,
    output logic             IDEX_RegWrite,
    output logic             IDEX_MemtoReg,
    output logic             IDEX_MemRead,
    output logic             IDEX_MemWrite,
    output logic             IDEX_ALUSrc,
    output logic             IDEX_Branch,
    output logic [1:0]       IDEX_ALUOp,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);
    logic            bubble;
    logic [XLEN-1:0] rs1_byp;
    logic [XLEN-1:0] rs2_byp;

    // Load-use hazard: a valid load in EX whose nonzero rd is read by the ID instruction
    always_comb begin
        stall  = IDEX_valid & IDEX_MemRead & (IDEX_rd != 5'd0) & id_valid & ~flush &
                 ((id_uses_rs1 & (id_rs1 == IDEX_rd)) | (id_uses_rs2 & (id_rs2 == IDEX_rd)));
        bubble = flush | stall | ~id_valid;
    end

    // Same-cycle WB write bypass; x0 is never bypassed
    always_comb begin
        rs1_byp = (wb_RegWrite && wb_rd != 5'd0 && wb_rd == id_rs1) ? wb_data : id_rs1_data;
        rs2_byp = (wb_RegWrite && wb_rd != 5'd0 && wb_rd == id_rs2) ? wb_data : id_rs2_data;
    end

    // Pipeline register: data always follows ID, control and rd cleared on a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            IDEX_valid    <= 1'b0;
            IDEX_pc       <= '0;
            IDEX_rs1_data <= '0;
            IDEX_rs2_data <= '0;
            IDEX_imm      <= '0;
            IDEX_rs1      <= 5'd0;
            IDEX_rs2      <= 5'd0;
            IDEX_rd       <= 5'd0;
            IDEX_funct3   <= 3'd0;
            IDEX_funct7b5 <= 1'b0;
            IDEX_RegWrite <= 1'b0;
            IDEX_MemtoReg <= 1'b0;
            IDEX_MemRead  <= 1'b0;
            IDEX_MemWrite <= 1'b0;
            IDEX_ALUSrc   <= 1'b0;
            IDEX_Branch   <= 1'b0;
            IDEX_ALUOp    <= 2'd0;
        end else begin
            IDEX_valid    <= ~bubble;
            IDEX_pc       <= id_pc;
            IDEX_rs1_data <= rs1_byp;
            IDEX_rs2_data <= rs2_byp;
            IDEX_imm      <= id_imm;
            IDEX_rs1      <= id_rs1;
            IDEX_rs2      <= id_rs2;
            IDEX_rd       <= bubble ? 5'd0 : id_rd;
            IDEX_funct3   <= id_funct3;
            IDEX_funct7b5 <= id_funct7b5;
            IDEX_RegWrite <= ~bubble & id_RegWrite;
            IDEX_MemtoReg <= ~bubble & id_MemtoReg;
            IDEX_MemRead  <= ~bubble & id_MemRead;
            IDEX_MemWrite <= ~bubble & id_MemWrite;
            IDEX_ALUSrc   <= ~bubble & id_ALUSrc;
            IDEX_Branch   <= ~bubble & id_Branch;
            IDEX_ALUOp    <= bubble ? 2'd0 : id_ALUOp;
        end
    end

    // Saturating stall-cycle counter, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage with a 4-bit-counter twin for saturation
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst, id_valid, flush;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        id_uses_rs1, id_uses_rs2, id_funct7b5, wb_RegWrite;
    logic [2:0]  id_funct3;
    logic        id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite, id_ALUSrc, id_Branch;
    logic [1:0]  id_ALUOp;

    logic        IDEX_valid, IDEX_funct7b5, stall;
    logic [31:0] IDEX_pc, IDEX_rs1_data, IDEX_rs2_data, IDEX_imm;
    logic [4:0]  IDEX_rs1, IDEX_rs2, IDEX_rd;
    logic [2:0]  IDEX_funct3;
    logic        IDEX_RegWrite, IDEX_MemtoReg, IDEX_MemRead, IDEX_MemWrite, IDEX_ALUSrc, IDEX_Branch;
    logic [1:0]  IDEX_ALUOp;
    logic [15:0] stall_cnt;

    logic        s_valid, s_funct7b5, s_stall;
    logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [2:0]  s_funct3;
    logic        s_RegWrite, s_MemtoReg, s_MemRead, s_MemWrite, s_ALUSrc, s_Branch;
    logic [1:0]  s_ALUOp;
    logic [3:0]  s_stall_cnt;

    always #5 clk = ~clk;

    id_ex_stage u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .flush(flush), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
        .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg), .id_MemRead(id_MemRead),
        .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc), .id_Branch(id_Branch), .id_ALUOp(id_ALUOp),
        .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .IDEX_valid(IDEX_valid), .IDEX_pc(IDEX_pc), .IDEX_rs1_data(IDEX_rs1_data),
        .IDEX_rs2_data(IDEX_rs2_data), .IDEX_imm(IDEX_imm),
        .IDEX_rs1(IDEX_rs1), .IDEX_rs2(IDEX_rs2), .IDEX_rd(IDEX_rd),
        .IDEX_funct3(IDEX_funct3), .IDEX_funct7b5(IDEX_funct7b5),
        .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemtoReg(IDEX_MemtoReg), .IDEX_MemRead(IDEX_MemRead),
        .IDEX_MemWrite(IDEX_MemWrite), .IDEX_ALUSrc(IDEX_ALUSrc), .IDEX_Branch(IDEX_Branch),
        .IDEX_ALUOp(IDEX_ALUOp), .stall(stall), .stall_cnt(stall_cnt)
    );

    id_ex_stage #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .flush(flush), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
        .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg), .id_MemRead(id_MemRead),
        .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc), .id_Branch(id_Branch), .id_ALUOp(id_ALUOp),
        .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .IDEX_valid(s_valid), .IDEX_pc(s_pc), .IDEX_rs1_data(s_rs1_data),
        .IDEX_rs2_data(s_rs2_data), .IDEX_imm(s_imm),
        .IDEX_rs1(s_rs1), .IDEX_rs2(s_rs2), .IDEX_rd(s_rd),
        .IDEX_funct3(s_funct3), .IDEX_funct7b5(s_funct7b5),
        .IDEX_RegWrite(s_RegWrite), .IDEX_MemtoReg(s_MemtoReg), .IDEX_MemRead(s_MemRead),
        .IDEX_MemWrite(s_MemWrite), .IDEX_ALUSrc(s_ALUSrc), .IDEX_Branch(s_Branch),
        .IDEX_ALUOp(s_ALUOp), .stall(s_stall), .stall_cnt(s_stall_cnt)
    );

    typedef struct {
        logic        full;
        logic        valid;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  r1, r2, rd;
        logic [2:0]  f3;
        logic        f7;
        logic [7:0]  ctl;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic        m_known = 1'b0;
    logic        m_valid, m_mr;
    logic [4:0]  m_rd;
    logic [15:0] m_cnt;
    logic [3:0]  m_cnt4;
    logic        last_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        exp_t e, o;
        logic es, bub;
        #1;
        es = m_valid & m_mr & (m_rd != 5'd0) & id_valid & ~flush &
             ((id_uses_rs1 & (id_rs1 == m_rd)) | (id_uses_rs2 & (id_rs2 == m_rd)));
        last_stall = stall;
        if (m_known) begin
            chk("stall", {63'd0, stall}, {63'd0, es});
            chk("stall_sat", {63'd0, s_stall}, {63'd0, es});
        end
        if (rst) begin
            e = '{1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 8'd0, 16'd0, 4'd0};
            m_known = 1'b1;
        end else begin
            bub     = flush | es | ~id_valid;
            e.full  = ~bub;
            e.valid = ~bub;
            e.pc    = id_pc;
            e.d1    = (wb_RegWrite && wb_rd != 0 && wb_rd == id_rs1) ? wb_data : id_rs1_data;
            e.d2    = (wb_RegWrite && wb_rd != 0 && wb_rd == id_rs2) ? wb_data : id_rs2_data;
            e.imm   = id_imm;
            e.r1    = id_rs1;
            e.r2    = id_rs2;
            e.rd    = bub ? 5'd0 : id_rd;
            e.f3    = id_funct3;
            e.f7    = id_funct7b5;
            e.ctl   = bub ? 8'd0 : {id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite,
                                    id_ALUSrc, id_Branch, id_ALUOp};
            e.cnt   = (es && m_cnt != 16'hFFFF) ? m_cnt + 16'd1 : m_cnt;
            e.cnt4  = (es && m_cnt4 != 4'hF) ? m_cnt4 + 4'd1 : m_cnt4;
        end
        m_valid = e.valid;
        m_mr    = e.ctl[5];
        m_rd    = e.rd;
        m_cnt   = e.cnt;
        m_cnt4  = e.cnt4;
        q.push_back(e);
        @(posedge clk);
        #1;
        o = q.pop_front();
        chk("valid", {63'd0, IDEX_valid}, {63'd0, o.valid});
        chk("rd", {59'd0, IDEX_rd}, {59'd0, o.rd});
        chk("ctl", {56'd0, IDEX_RegWrite, IDEX_MemtoReg, IDEX_MemRead, IDEX_MemWrite,
                    IDEX_ALUSrc, IDEX_Branch, IDEX_ALUOp}, {56'd0, o.ctl});
        chk("cnt", {48'd0, stall_cnt}, {48'd0, o.cnt});
        chk("cnt_sat", {60'd0, s_stall_cnt}, {60'd0, o.cnt4});
        if (o.full) begin
            chk("pc", {32'd0, IDEX_pc}, {32'd0, o.pc});
            chk("rs1_data", {32'd0, IDEX_rs1_data}, {32'd0, o.d1});
            chk("rs2_data", {32'd0, IDEX_rs2_data}, {32'd0, o.d2});
            chk("imm", {32'd0, IDEX_imm}, {32'd0, o.imm});
            chk("idx", {54'd0, IDEX_rs1, IDEX_rs2}, {54'd0, o.r1, o.r2});
            chk("funct", {60'd0, IDEX_funct3, IDEX_funct7b5}, {60'd0, o.f3, o.f7});
        end
    endtask

    task automatic ins(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic ld);
        id_valid    = 1'b1;
        id_pc       = $urandom;
        id_rs1_data = $urandom;
        id_rs2_data = $urandom;
        id_imm      = $urandom;
        id_rs1      = r1;
        id_rs2      = r2;
        id_rd       = rd;
        id_uses_rs1 = u1;
        id_uses_rs2 = u2;
        id_funct3   = 3'($urandom);
        id_funct7b5 = 1'($urandom);
        id_RegWrite = 1'b1;
        id_MemtoReg = ld;
        id_MemRead  = ld;
        id_MemWrite = 1'b0;
        id_ALUSrc   = ld;
        id_Branch   = 1'b0;
        id_ALUOp    = ld ? 2'b00 : 2'b10;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        wb_RegWrite = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        ins(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1);
        step();
        step();
        chk("rst_valid", {63'd0, IDEX_valid}, 64'd0);
        chk("rst_cnt", {48'd0, stall_cnt}, 64'd0);
        rst = 1'b0;
        // lw x5,0(x1) ; add x6,x5,x2
        ins(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
        step();
        ins(5'd5, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0);
        step();
        chk("lu_stall", {63'd0, last_stall}, 64'd1);
        chk("lu_bubble", {58'd0, IDEX_valid, IDEX_rd}, 64'd0);
        chk("lu_cnt", {48'd0, stall_cnt}, 64'd1);
        step();
        chk("lu_stall_drop", {63'd0, last_stall}, 64'd0);
        chk("lu_issue", {58'd0, IDEX_valid, IDEX_rs1}, {58'd0, 1'b1, 5'd5});
        // load to x0 then use of x0
        ins(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
        step();
        ins(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        step();
        chk("x0_nostall", {63'd0, last_stall}, 64'd0);
        // load x5 then rs2=5 unused
        ins(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
        step();
        ins(5'd4, 5'd5, 5'd8, 1'b1, 1'b0, 1'b0);
        step();
        chk("unused_nostall", {63'd0, last_stall}, 64'd0);
        // WB bypass
        wb_RegWrite = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
        ins(5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 1'b0);
        id_rs1_data = 32'd0;
        step();
        chk("bypass", {32'd0, IDEX_rs1_data}, 64'hDEADBEEF);
        wb_rd = 5'd0;
        ins(5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 1'b0);
        id_rs1_data = 32'd0;
        step();
        chk("bypass_x0", {32'd0, IDEX_rs1_data}, 64'd0);
        wb_RegWrite = 1'b0;
        // flush during hazard
        ins(5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1);
        step();
        ins(5'd7, 5'd2, 5'd10, 1'b1, 1'b1, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_nostall", {63'd0, last_stall}, 64'd0);
        chk("flush_cnt", {48'd0, stall_cnt}, 64'd1);
        // bypass and load-use on the same register
        ins(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
        step();
        wb_RegWrite = 1'b1; wb_rd = 5'd5; wb_data = 32'h12345678;
        ins(5'd5, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0);
        step();
        step();
        chk("byp_after_stall", {32'd0, IDEX_rs1_data}, 64'h12345678);
        wb_RegWrite = 1'b0;
        // idle slots
        id_valid = 1'b0;
        repeat (2) step();
        // repeated lw x5,0(x5) drives a stall every other cycle
        ins(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
        repeat (46) step();
        chk("sat4", {60'd0, s_stall_cnt}, 64'd15);
        // reset mid-stream on top of flush and hazard
        ins(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
        rst = 1'b1; flush = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0;
        step();
        chk("post_rst_nostall", {63'd0, last_stall}, 64'd0);
        // randomized traffic on a small register set
        for (int i = 0; i < 300; i++) begin
            ins(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 1'($urandom));
            id_valid    = ($urandom_range(0, 3) != 0);
            id_MemWrite = 1'($urandom);
            id_Branch   = 1'($urandom);
            id_ALUOp    = 2'($urandom);
            flush       = ($urandom_range(0, 7) == 0);
            rst         = ($urandom_range(0, 39) == 0);
            wb_RegWrite = 1'($urandom);
            wb_rd       = 5'($urandom_range(0, 3));
            wb_data     = $urandom;
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage RV32I pipeline. It registers decoded operands and control from ID into the EX stage, and drives the `IDEX_rs1`/`IDEX_rs2`/`IDEX_rd` fields that the forwarding unit compares against EX/MEM and MEM/WB. The block also:
- detects load-use hazards and inserts bubbles,
- bypasses same-cycle register-file writes from WB,
- applies branch flushes,
- counts stall cycles for performance monitoring.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `CNT_W`, 16, stall-counter width.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: ID holds a real instruction.
- `flush` in 1: branch/jump taken in EX; squash the ID instruction.
- `id_pc` in XLEN: PC of the ID instruction.
- `id_rs1_data`, `id_rs2_data` in XLEN: register-file read data.
- `id_imm` in XLEN: immediate.
- `id_rs1`, `id_rs2`, `id_rd` in 5: register indices.
- `id_uses_rs1`, `id_uses_rs2` in 1: the instruction actually reads rs1/rs2.
- `id_funct3` in 3; `id_funct7b5` in 1.
- `id_RegWrite`, `id_MemtoReg`, `id_MemRead`, `id_MemWrite`, `id_ALUSrc`, `id_Branch` in 1; `id_ALUOp` in 2.
- `wb_RegWrite` in 1; `wb_rd` in 5; `wb_data` in XLEN: WB write port.
- `IDEX_valid` out 1; `IDEX_pc`, `IDEX_rs1_data`, `IDEX_rs2_data`, `IDEX_imm` out XLEN.
- `IDEX_rs1`, `IDEX_rs2`, `IDEX_rd` out 5; `IDEX_funct3` out 3; `IDEX_funct7b5` out 1.
- `IDEX_RegWrite`, `IDEX_MemtoReg`, `IDEX_MemRead`, `IDEX_MemWrite`, `IDEX_ALUSrc`, `IDEX_Branch` out 1; `IDEX_ALUOp` out 2.
- `stall` out 1: combinational; hold PC and IF/ID when high.
- `stall_cnt` out CNT_W: saturating count of stall cycles.

## Operation
- Hazard detection (combinational):
  - `stall = IDEX_valid & IDEX_MemRead & (IDEX_rd != 0) & id_valid & ~flush & ((id_uses_rs1 & id_rs1 == IDEX_rd) | (id_uses_rs2 & id_rs2 == IDEX_rd))`.
- WB bypass (combinational):
  - Captured rs1 value = `wb_data` if `wb_RegWrite & wb_rd != 0 & wb_rd == id_rs1`; otherwise `id_rs1_data`.
  - rs2 uses the same rule.
- Register update each edge, first matching row wins:
  1. `rst`: all outputs 0, `stall_cnt` = 0.
  2. `flush`: bubble.
  3. `stall`: bubble; `stall_cnt` increments.
  4. `~id_valid`: bubble.
  5. Otherwise: load all `id_*` fields (bypassed data) and set `IDEX_valid` = 1.
- Bubble definition:
  - Cleared: `IDEX_valid`, RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc, ALUOp, and `IDEX_rd`.
  - Data, index and funct fields load from ID as normal (don't-care).
  - `IDEX_rd` = 0 guarantees the forwarding unit never matches a bubble.
- `stall_cnt` saturates at all-ones and never wraps. Only `rst` clears it.
- The block has no FSM; its state is the pipeline register plus the counter.

## Timing
- Latency: ID inputs appear on `IDEX_*` one cycle after the edge that samples them.
- `stall` depends only on registered `IDEX_*` and current ID inputs, so it is valid in the same cycle.
- A load-use stall lasts exactly one cycle. After the bubble, `IDEX_MemRead` = 0, so `stall` drops and the held instruction issues. The loaded value is then forwarded from MEM/WB.
- `flush` and `stall` in the same cycle: `stall` is 0 by definition and a bubble is loaded. The counter does not increment.
- Reset asserted mid-stream: the next edge clears everything regardless of `flush`/`stall`. The first post-reset cycle has `stall` = 0.
- WB bypass and load-use on the same register: the stall takes priority; the bypass applies on the issue cycle.
- Register x0 is never bypassed and never causes a stall.

## Test plan
- Reset: hold `rst` 2 cycles with `id_valid` = 1 → every output 0, `stall` = 0, `stall_cnt` = 0.
- Load-use: `lw x5,0(x1)` then `add x6,x5,x2` →
  - `stall` = 1 for one cycle;
  - `IDEX_valid` = 0 and `IDEX_rd` = 0 for that cycle;
  - `add` issues next cycle with `IDEX_rs1` = 5;
  - `stall_cnt` = 1.
- Non-hazards, no stall expected:
  - load to x0 followed by a use of x0 → `stall` = 0;
  - load x5 followed by an instruction with `id_uses_rs2` = 0 and `id_rs2` = 5 → `stall` = 0.
- WB bypass: `wb_RegWrite` = 1, `wb_rd` = 3, `wb_data` = 0xDEADBEEF, `id_rs1` = 3, `id_rs1_data` = 0x0 → `IDEX_rs1_data` = 0xDEADBEEF next cycle. With `wb_rd` = 0 → 0x0.
- Flush during hazard: load-use condition plus `flush` = 1 → `stall` = 0, bubble loaded, `stall_cnt` unchanged.
- Saturation: `CNT_W` = 4, force 20 stall cycles → `stall_cnt` = 15 and holds.
